// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - flow-to-stream mapping and matcher cycle sequencing for the DPI regex bank
//
// Purpose: accepts one packet at a time (flow key, then payload bytes), maps the
// key to a 6-bit stream id through a 64-entry table, drives the category matchers
// through load / wait / stream / drain / eop, and reports the per-category fired
// vector for the packet.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   pkt_key / _vld / _rdy            flow key handshake (accepted only in IDLE)
//   byte_in / _vld / _rdy / _last    payload byte handshake (accepted only in STREAM)
//   cfg_we, cfg_stream, cfg_mask     per-stream category enable mask write
//   load_state, stream_id,
//   new_stream_id, enable            matcher state restore / reset controls
//   char_out, char_out_vld           registered character beat to the matchers
//   eop                              finalize and save matcher state
//   fired                            speculative match flags from the matchers
//   res_vld, res_stream_id,
//   res_new, res_fired               one-cycle per-packet result
//   stat_pkts                        completed packet counter (wraps)
module dpi_stream_sequencer #(
    parameter int NUM_CAT   = 8,
    parameter int KEY_W     = 32,
    parameter int DRAIN_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   pkt_key,
    input  logic               pkt_key_vld,
    output logic               pkt_key_rdy,
    input  logic [7:0]         byte_in,
    input  logic               byte_vld,
    output logic               byte_rdy,
    input  logic               byte_last,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_stream,
    input  logic [NUM_CAT-1:0] cfg_mask,
    output logic               load_state,
    output logic [5:0]         stream_id,
    output logic               new_stream_id,
    output logic [NUM_CAT-1:0] enable,
    output logic [7:0]         char_out,
    output logic               char_out_vld,
    output logic               eop,
    input  logic [NUM_CAT-1:0] fired,
    output logic               res_vld,
    output logic [5:0]         res_stream_id,
    output logic               res_new,
    output logic [NUM_CAT-1:0] res_fired,
    output logic [15:0]        stat_pkts
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;
    localparam logic [2:0] ST_EOP    = 3'd6;
    localparam logic [2:0] ST_RESULT = 3'd7;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [2:0]         state_q, state_d;
    logic [KEY_W-1:0]   key_q;
    logic               tbl_vld_q [64];
    logic [KEY_W-1:0]   tbl_key_q [64];
    logic [NUM_CAT-1:0] cfg_mem_q [64];
    logic [5:0]         repl_ptr_q;
    logic [5:0]         stream_id_q, stream_id_d;
    logic               is_new_q, is_new_d;
    logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
    logic               pkt_key_rdy_q;
    logic               load_state_q;
    logic               new_stream_id_q;
    logic [NUM_CAT-1:0] enable_q;
    logic               byte_rdy_q;
    logic [7:0]         char_out_q;
    logic               char_out_vld_q;
    logic               eop_q;
    logic               res_vld_q;
    logic [5:0]         res_stream_id_q;
    logic               res_new_q;
    logic [NUM_CAT-1:0] res_fired_q;
    logic [15:0]        stat_pkts_q;

    logic               key_xfer, byte_xfer;
    logic               hit, free_found;
    logic [5:0]         hit_idx, free_idx, lk_idx;
    logic               tbl_we, repl_adv;

    // Ready flags are only ever high in their own state, so these are the
    // only places a transfer can occur.
    assign key_xfer  = pkt_key_vld && pkt_key_rdy_q;
    assign byte_xfer = byte_vld && byte_rdy_q;

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 63; i >= 0; i--) begin
            if (tbl_vld_q[i] && (tbl_key_q[i] == key_q)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
            if (!tbl_vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = 6'(i);
            end
        end
    end

    assign lk_idx = hit ? hit_idx : (free_found ? free_idx : repl_ptr_q);

    always_comb begin
        state_d     = state_q;
        stream_id_d = stream_id_q;
        is_new_d    = is_new_q;
        drain_cnt_d = drain_cnt_q;
        tbl_we      = 1'b0;
        repl_adv    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_xfer) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                stream_id_d = lk_idx;
                is_new_d    = !hit;
                tbl_we      = !hit;
                // Round-robin eviction only advances when the table is full.
                repl_adv    = !hit && !free_found;
                state_d     = ST_LOAD;
            end
            ST_LOAD:   state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_STREAM;
            ST_STREAM: begin
                if (byte_xfer && byte_last) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                // The first DRAIN cycle carries the registered last character,
                // so DRAIN_CYC cycles here put eop DRAIN_CYC after that beat.
                if (drain_cnt_q == '0) state_d = ST_EOP;
                else                   drain_cnt_d = drain_cnt_q - 1'b1;
            end
            ST_EOP:    state_d = ST_RESULT;
            ST_RESULT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            key_q           <= '0;
            repl_ptr_q      <= '0;
            stream_id_q     <= '0;
            is_new_q        <= 1'b0;
            drain_cnt_q     <= '0;
            pkt_key_rdy_q   <= 1'b0;
            load_state_q    <= 1'b0;
            new_stream_id_q <= 1'b0;
            enable_q        <= '0;
            byte_rdy_q      <= 1'b0;
            char_out_q      <= '0;
            char_out_vld_q  <= 1'b0;
            eop_q           <= 1'b0;
            res_vld_q       <= 1'b0;
            res_stream_id_q <= '0;
            res_new_q       <= 1'b0;
            res_fired_q     <= '0;
            stat_pkts_q     <= '0;
            for (int i = 0; i < 64; i++) begin
                tbl_vld_q[i] <= 1'b0;
                tbl_key_q[i] <= '0;
                cfg_mem_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            stream_id_q     <= stream_id_d;
            is_new_q        <= is_new_d;
            drain_cnt_q     <= drain_cnt_d;
            // Strobes and readies are decoded from the next state so they
            // line up with the state they belong to.
            pkt_key_rdy_q   <= (state_d == ST_IDLE);
            load_state_q    <= (state_d == ST_LOAD);
            new_stream_id_q <= (state_d == ST_LOAD) && is_new_d;
            byte_rdy_q      <= (state_d == ST_STREAM);
            eop_q           <= (state_d == ST_EOP);
            res_vld_q       <= (state_d == ST_RESULT);
            char_out_vld_q  <= byte_xfer;
            if (byte_xfer) char_out_q <= byte_in;
            if (key_xfer) key_q <= pkt_key;
            if (tbl_we) begin
                tbl_vld_q[lk_idx] <= 1'b1;
                tbl_key_q[lk_idx] <= key_q;
            end
            if (repl_adv) repl_ptr_q <= repl_ptr_q + 6'd1;
            if (cfg_we) cfg_mem_q[cfg_stream] <= cfg_mask;
            // Reads the pre-write mask, so a same-cycle cfg write to this id
            // only affects the next packet.
            if (state_q == ST_LOAD) enable_q <= cfg_mem_q[stream_id_q];
            if (state_q == ST_EOP) begin
                res_fired_q     <= fired & enable_q;
                res_stream_id_q <= stream_id_q;
                res_new_q       <= is_new_q;
                stat_pkts_q     <= stat_pkts_q + 16'd1;
            end
        end
    end

    assign pkt_key_rdy   = pkt_key_rdy_q;
    assign byte_rdy      = byte_rdy_q;
    assign load_state    = load_state_q;
    assign stream_id     = stream_id_q;
    assign new_stream_id = new_stream_id_q;
    assign enable        = enable_q;
    assign char_out      = char_out_q;
    assign char_out_vld  = char_out_vld_q;
    assign eop           = eop_q;
    assign res_vld       = res_vld_q;
    assign res_stream_id = res_stream_id_q;
    assign res_new       = res_new_q;
    assign res_fired     = res_fired_q;
    assign stat_pkts     = stat_pkts_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb/tb_dpi_stream_sequencer.sv - directed bench for dpi_stream_sequencer
module tb_dpi_stream_sequencer;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pkt_key = '0;
    logic        pkt_key_vld = 1'b0;
    logic        pkt_key_rdy;
    logic [7:0]  byte_in = '0;
    logic        byte_vld = 1'b0;
    logic        byte_rdy;
    logic        byte_last = 1'b0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_stream = '0;
    logic [7:0]  cfg_mask = '0;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic [7:0]  enable;
    logic [7:0]  char_out;
    logic        char_out_vld;
    logic        eop;
    logic [7:0]  fired = '0;
    logic        res_vld;
    logic [5:0]  res_stream_id;
    logic        res_new;
    logic [7:0]  res_fired;
    logic [15:0] stat_pkts;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_stat = 0;

    always #5 clk = ~clk;

    dpi_stream_sequencer #(.NUM_CAT(8), .KEY_W(32), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_key(pkt_key), .pkt_key_vld(pkt_key_vld), .pkt_key_rdy(pkt_key_rdy),
        .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(byte_rdy), .byte_last(byte_last),
        .cfg_we(cfg_we), .cfg_stream(cfg_stream), .cfg_mask(cfg_mask),
        .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .enable(enable), .char_out(char_out), .char_out_vld(char_out_vld), .eop(eop),
        .fired(fired), .res_vld(res_vld), .res_stream_id(res_stream_id), .res_new(res_new),
        .res_fired(res_fired), .stat_pkts(stat_pkts)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Drives one packet; cycle 0 is the key transfer cycle. Junk key/byte
    // handshakes are offered whenever the DUT is not ready, and must be ignored.
    task automatic run_pkt(input logic [31:0] key, input int n, input bit gap,
                           input logic [7:0] fire, input int cfg_cyc,
                           input logic [5:0] cfg_id, input logic [7:0] cfg_m,
                           input logic [5:0] exp_id, input bit exp_new,
                           input logic [7:0] exp_en);
        int c, t, nsent, nseen, last_c, load_c, eop_c, res_c, rdy_c, neop;
        logic [7:0] base, e;
        logic [5:0] g_id;
        logic       g_new;
        logic [7:0] g_en;
        bit         done;
        base = key[7:0] ^ 8'h5A;
        t = 0;
        while (!pkt_key_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("key_rdy", {31'd0, pkt_key_rdy}, 32'd1);
        fired = fire;
        pkt_key = key;
        pkt_key_vld = 1'b1;
        c = 0; nsent = 0; nseen = 0; last_c = -100; load_c = -1; eop_c = -1;
        res_c = -1; rdy_c = -1; neop = 0; done = 1'b0;
        g_id = '0; g_new = 1'b0; g_en = '0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            if (load_state) begin
                load_c = c;
                g_id = stream_id;
                g_new = new_stream_id;
            end
            if (byte_rdy && rdy_c < 0) rdy_c = c;
            if (char_out_vld) begin
                e = base + 8'(nseen);
                chk("char", {24'd0, char_out}, {24'd0, e});
                nseen++;
            end
            if (eop) begin
                eop_c = c;
                neop++;
                g_en = enable;
            end
            if (res_vld) begin
                res_c = c;
                done = 1'b1;
            end
            cfg_we = (c == cfg_cyc);
            cfg_stream = cfg_id;
            cfg_mask = cfg_m;
            if (done) begin
                pkt_key_vld = 1'b0;
                byte_vld = 1'b0;
                byte_last = 1'b0;
            end else begin
                pkt_key_vld = 1'b1;
                pkt_key = 32'hDEAD_BEEF;
                if (byte_rdy && nsent < n && (!gap || (c % 2 == 0))) begin
                    byte_in = base + 8'(nsent);
                    byte_vld = 1'b1;
                    byte_last = (nsent == n - 1);
                    if (nsent == n - 1) last_c = c;
                    nsent++;
                end else begin
                    byte_vld = !byte_rdy;
                    byte_in = 8'hEE;
                    byte_last = 1'b1;
                end
            end
        end
        cfg_we = 1'b0;
        pkt_key_vld = 1'b0;
        byte_vld = 1'b0;
        chk("res_seen", {31'd0, done}, 32'd1);
        chk("load_cyc", load_c, 32'd2);
        chk("rdy_cyc", rdy_c, 32'd4);
        chk("load_id", {26'd0, g_id}, {26'd0, exp_id});
        chk("load_new", {31'd0, g_new}, {31'd0, exp_new});
        chk("nchars", nseen, n);
        chk("neop", neop, 32'd1);
        chk("eop_lat", eop_c - last_c, DRAIN + 1);
        chk("res_lat", res_c - last_c, DRAIN + 2);
        chk("eop_enable", {24'd0, g_en}, {24'd0, exp_en});
        chk("res_id", {26'd0, res_stream_id}, {26'd0, exp_id});
        chk("res_new", {31'd0, res_new}, {31'd0, exp_new});
        chk("res_fired", {24'd0, res_fired}, {24'd0, fire & exp_en});
        exp_stat++;
        chk("stat_pkts", {16'd0, stat_pkts}, exp_stat);
        @(negedge clk);
        chk("key_rdy_after", {31'd0, pkt_key_rdy}, 32'd1);
    endtask

    task automatic cfg_write(input logic [5:0] id, input logic [7:0] m);
        cfg_we = 1'b1;
        cfg_stream = id;
        cfg_mask = m;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        int t, nbad;
        repeat (3) @(negedge clk);
        chk("rst_key_rdy", {31'd0, pkt_key_rdy}, 32'd0);
        chk("rst_stat", {16'd0, stat_pkts}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_key_rdy", {31'd0, pkt_key_rdy}, 32'd1);
        chk("rel_byte_rdy", {31'd0, byte_rdy}, 32'd0);
        chk("rel_enable", {24'd0, enable}, 32'd0);
        chk("rel_res_vld", {31'd0, res_vld}, 32'd0);

        // first packet allocates id 0, masks still zero
        run_pkt(32'hAABB_0001, 3, 1'b0, 8'h08, -1, 6'd0, 8'h00, 6'd0, 1'b1, 8'h00);
        // hit on id 0 with mask enabled
        cfg_write(6'd0, 8'hFF);
        run_pkt(32'hAABB_0001, 3, 1'b0, 8'h08, -1, 6'd0, 8'h00, 6'd0, 1'b0, 8'hFF);
        // bubbles every other cycle across 5 bytes
        run_pkt(32'hAABB_0001, 5, 1'b1, 8'h81, -1, 6'd0, 8'h00, 6'd0, 1'b0, 8'hFF);
        // cfg write during STREAM: in-flight enable unchanged, next packet sees it
        run_pkt(32'hAABB_0001, 4, 1'b0, 8'hFF, 5, 6'd0, 8'h0F, 6'd0, 1'b0, 8'hFF);
        run_pkt(32'hAABB_0001, 2, 1'b0, 8'hFF, -1, 6'd0, 8'h00, 6'd0, 1'b0, 8'h0F);
        // cfg write in the LOAD cycle itself is not seen by that packet
        run_pkt(32'hAABB_0001, 2, 1'b0, 8'hFF, 2, 6'd0, 8'h3C, 6'd0, 1'b0, 8'h0F);
        run_pkt(32'hAABB_0001, 1, 1'b0, 8'hFF, -1, 6'd0, 8'h00, 6'd0, 1'b0, 8'h3C);

        // fill ids 1..63
        for (int i = 1; i < 64; i++)
            run_pkt(32'h1000_0000 + i, 1, 1'b0, 8'h00, -1, 6'd0, 8'h00, 6'(i), 1'b1, 8'h00);
        // 64 evictions walk repl_ptr 0..63; id 0 keeps its mask through eviction
        for (int i = 0; i < 64; i++)
            run_pkt(32'h2000_0000 + i, 1, 1'b0, 8'hFF, -1, 6'd0, 8'h00, 6'(i), 1'b1,
                    (i == 0) ? 8'h3C : 8'h00);
        // pointer wrapped back to 0
        run_pkt(32'h2000_0040, 1, 1'b0, 8'hFF, -1, 6'd0, 8'h00, 6'd0, 1'b1, 8'h3C);
        // surviving entry still hits
        run_pkt(32'h2000_0001, 2, 1'b0, 8'hFF, -1, 6'd0, 8'h00, 6'd1, 1'b0, 8'h00);

        // reset in the middle of STREAM
        pkt_key = 32'h4444_0000;
        pkt_key_vld = 1'b1;
        @(negedge clk);
        pkt_key_vld = 1'b0;
        t = 0;
        while (!byte_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_byte_rdy", {31'd0, byte_rdy}, 32'd1);
        byte_in = 8'h11;
        byte_vld = 1'b1;
        byte_last = 1'b0;
        @(negedge clk);
        byte_vld = 1'b0;
        chk("abort_char_vld", {31'd0, char_out_vld}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_key_rdy", {31'd0, pkt_key_rdy}, 32'd0);
        chk("abort_byte_rdy0", {31'd0, byte_rdy}, 32'd0);
        chk("abort_char_vld0", {31'd0, char_out_vld}, 32'd0);
        chk("abort_char", {24'd0, char_out}, 32'd0);
        chk("abort_stream_id", {26'd0, stream_id}, 32'd0);
        chk("abort_enable", {24'd0, enable}, 32'd0);
        chk("abort_stat", {16'd0, stat_pkts}, 32'd0);
        nbad = 0;
        for (int i = 0; i < 12; i++) begin
            if (eop || res_vld) nbad++;
            @(negedge clk);
        end
        chk("abort_no_eop", nbad, 32'd0);
        exp_stat = 0;
        // table and masks cleared: previously-hit key is new at id 0, mask 0
        run_pkt(32'h2000_0001, 3, 1'b0, 8'hFF, -1, 6'd0, 8'h00, 6'd0, 1'b1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
